// File: rtl/ps2_key_event_queue_if.sv
// rtl/ps2_key_event_queue_if.sv - scan-code byte stream in, key event stream out
interface ps2_key_event_queue_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [8:0] ev_code;
  logic       ev_break;
  logic       ev_valid;
  logic       ev_ready;

  modport master (
    output byte_in, byte_valid, ev_ready,
    input  ev_code, ev_break, ev_valid
  );

  modport slave (
    input  byte_in, byte_valid, ev_ready,
    output ev_code, ev_break, ev_valid
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// rtl/ps2_key_event_queue.sv - PS/2 scan-code decoder with key bitmap and FWFT event FIFO
// Optional macro TYPEMATIC_FILTER_EN drops auto-repeat makes for keys already held.
module ps2_key_event_queue #(
  parameter int       FIFO_DEPTH  = 8,
  parameter bit       REQUIRE_BAT = 1'b1,
  parameter bit [8:0] PAUSE_CODE  = 9'h1FF
) (
  input  logic                          clk,
  input  logic                          rst,
  ps2_key_event_queue_if.slave          bus,
  output logic [511:0]                  key_down,
  output logic [9:0]                    keys_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          kb_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_PREFIX, S_SKIP} state_t;

  state_t     state;
  logic       ext, brk;
  logic [2:0] skip_cnt;

  logic       in_decode, is_ctrl;
  logic       dec_push, dec_key, dec_brk;
  logic [8:0] dec_code;
  logic       fifo_full, fifo_pop, push_ok, push_drop;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    head;

  assign in_decode = bus.byte_valid && (state == S_IDLE || state == S_PREFIX);
  assign is_ctrl   = bus.byte_in inside {8'hFA, 8'hEE, 8'h00, 8'hFF, 8'hAA, 8'hE0, 8'hF0};

  always_comb begin
    dec_push = 1'b0;
    dec_key  = 1'b0;
    dec_brk  = 1'b0;
    dec_code = '0;
    if (in_decode && !is_ctrl) begin
      if (bus.byte_in == 8'hE1 && state == S_IDLE) begin
        dec_push = 1'b1;
        dec_code = PAUSE_CODE;
      end else begin
        dec_key  = 1'b1;
        dec_push = 1'b1;
        dec_brk  = brk;
        dec_code = {ext, bus.byte_in};
`ifdef TYPEMATIC_FILTER_EN
        if (!brk && key_down[{ext, bus.byte_in}]) dec_push = 1'b0;
`else
`endif
      end
    end
  end

  assign fifo_full = (fifo_count == DEPTH_C);
  assign fifo_pop  = (fifo_count != '0) && bus.ev_ready;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_ok   = dec_push && (!fifo_full || fifo_pop);
  assign push_drop = dec_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQUIRE_BAT ? S_INIT : S_IDLE;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip_cnt  <= '0;
      kb_ready  <= !REQUIRE_BAT;
      key_down  <= '0;
      keys_held <= '0;
      overflow  <= 1'b0;
    end else begin
      if (clr_overflow) overflow <= 1'b0;
      if (push_drop)    overflow <= 1'b1;
      if (bus.byte_valid) begin
        case (state)
          S_INIT: begin
            if (bus.byte_in == 8'hAA) begin
              state    <= S_IDLE;
              kb_ready <= 1'b1;
            end
          end
          S_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state <= S_IDLE;
          end
          default: begin
            case (bus.byte_in)
              8'hFA, 8'hEE: begin
              end
              8'h00, 8'hFF: begin
                ext   <= 1'b0;
                brk   <= 1'b0;
                state <= S_IDLE;
              end
              // Late BAT means the keyboard was re-plugged: nothing is held any more.
              8'hAA: begin
                key_down  <= '0;
                keys_held <= '0;
                ext       <= 1'b0;
                brk       <= 1'b0;
                state     <= S_IDLE;
              end
              8'hE0: begin
                ext   <= 1'b1;
                state <= S_PREFIX;
              end
              8'hF0: begin
                brk   <= 1'b1;
                state <= S_PREFIX;
              end
              default: begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!dec_key) begin
                  state    <= S_SKIP;
                  skip_cnt <= 3'd7;
                end else begin
                  state <= S_IDLE;
                  if (dec_brk) begin
                    if (key_down[dec_code]) begin
                      key_down[dec_code] <= 1'b0;
                      keys_held          <= keys_held - 10'd1;
                    end
                  end else if (!key_down[dec_code]) begin
                    key_down[dec_code] <= 1'b1;
                    keys_held          <= keys_held + 10'd1;
                  end
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {dec_brk, dec_code};
  end

  assign head         = mem[rd_ptr];
  assign bus.ev_valid = (fifo_count != '0);
  assign bus.ev_code  = bus.ev_valid ? head[8:0] : '0;
  assign bus.ev_break = bus.ev_valid & head[9];
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb/tb_ps2_key_event_queue.sv - directed self-checking bench for ps2_key_event_queue
module tb_ps2_key_event_queue;
  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [9:0]   keys_held;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic         clr_overflow;
  logic         kb_ready;
  int           checks = 0;
  int           failures = 0;

  ps2_key_event_queue_if bus();

  ps2_key_event_queue #(.FIFO_DEPTH(8), .REQUIRE_BAT(1'b1), .PAUSE_CODE(9'h1FF)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .key_down     (key_down),
    .keys_held    (keys_held),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .kb_ready     (kb_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pause_seq [8];
    logic [8:0] drain_exp [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    drain_exp = '{9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016, 9'h017, 9'h022};

    rst = 1'b1; clr_overflow = 1'b0;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ev_valid", bus.ev_valid, 0);
    check("rst_ev_code", bus.ev_code, 0);
    check("rst_kb_ready", kb_ready, 0);
    check("rst_keys_held", keys_held, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_key_down_any", |key_down, 0);
    rst = 1'b0;

    // Bytes before BAT are ignored
    send(8'h1C);
    check("prebat_ev_valid", bus.ev_valid, 0);
    check("prebat_kb_ready", kb_ready, 0);
    send(8'hAA);
    check("bat_kb_ready", kb_ready, 1);
    check("bat_ev_valid", bus.ev_valid, 0);

    // First make: visible one cycle after the strobe
    send(8'h1C);
    check("make_ev_valid", bus.ev_valid, 1);
    check("make_ev_code", bus.ev_code, 9'h01C);
    check("make_ev_break", bus.ev_break, 0);
    check("make_key28", key_down[28], 1);
    check("make_keys_held", keys_held, 1);
    pop();
    check("pop_fifo_count", fifo_count, 0);
    send(8'hF0); send(8'h1C);
    check("brk_ev_code", bus.ev_code, 9'h01C);
    check("brk_ev_break", bus.ev_break, 1);
    check("brk_keys_held", keys_held, 0);
    pop();

    // Extended make and break
    send(8'hE0); send(8'h75);
    check("ext_make_code", bus.ev_code, 9'h175);
    check("ext_make_break", bus.ev_break, 0);
    check("ext_make_key", key_down[373], 1);
    check("ext_make_held", keys_held, 1);
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_brk_code", bus.ev_code, 9'h175);
    check("ext_brk_break", bus.ev_break, 1);
    check("ext_brk_key", key_down[373], 0);
    check("ext_brk_held", keys_held, 0);
    pop();

    // Break for an unheld key is queued but leaves the count alone
    send(8'hF0); send(8'h33);
    check("unheld_brk_valid", bus.ev_valid, 1);
    check("unheld_brk_held", keys_held, 0);
    pop();

    // Typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    check("typematic_count", fifo_count, 1);
    pop();
`else
    check("typematic_count", fifo_count, 3);
    pop(); pop(); pop();
`endif
    check("typematic_held", keys_held, 1);
    check("typematic_drained", fifo_count, 0);
    send(8'hF0); send(8'h1C);
    pop();

    // Pause sequence yields a single make event
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    check("pause_count", fifo_count, 1);
    check("pause_code", bus.ev_code, 9'h1FF);
    check("pause_break", bus.ev_break, 0);
    check("pause_held", keys_held, 0);
    check("pause_key14", key_down[9'h014], 0);
    pop();
    send(8'h1C);
    check("post_pause_code", bus.ev_code, 9'h01C);
    check("post_pause_held", keys_held, 1);
    pop();
    send(8'hF0); send(8'h1C);
    pop();

    // Error byte after F0 clears the pending break
    send(8'hF0); send(8'hFF); send(8'h1C);
    check("err_code", bus.ev_code, 9'h01C);
    check("err_break", bus.ev_break, 0);
    pop();
    send(8'hF0); send(8'h1C);
    pop();
    send(8'hFA); send(8'hEE);
    check("ack_echo_ignored", fifo_count, 0);

    // Pop while empty
    pop();
    check("empty_pop_count", fifo_count, 0);

    // Fill, overflow, then simultaneous push and pop at full
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    check("full_count", fifo_count, 8);
    check("full_no_overflow", overflow, 0);
    send(8'h21);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_key21", key_down[9'h021], 1);
    check("ovf_held", keys_held, 9);
    @(negedge clk);
    bus.byte_in = 8'h22; bus.byte_valid = 1'b1; bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0; bus.ev_ready = 1'b0;
    check("pushpop_count", fifo_count, 8);
    check("pushpop_head", bus.ev_code, 9'h011);
    check("pushpop_held", keys_held, 10);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    check("clr_overflow", overflow, 0);

    // Re-plug clears key state but keeps queued events
    send(8'hAA);
    check("replug_key_any", |key_down, 0);
    check("replug_held", keys_held, 0);
    check("replug_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), bus.ev_code, drain_exp[i]);
      pop();
    end
    check("drain_valid", bus.ev_valid, 0);

    // Reset in the middle of a break sequence
    send(8'hF0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_kb_ready", kb_ready, 0);
    check("midrst_count", fifo_count, 0);
    send(8'hAA); send(8'h1C);
    check("midrst_code", bus.ev_code, 9'h01C);
    check("midrst_break", bus.ev_break, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
